// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard/sequencing controller.
// The master side is the controller; the slave side is the datapath it steers.
interface hazard_ctrl_if;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [9:0]  id_ctrl;
    logic [9:0]  ex_ctrl;
    logic [4:0]  ex_rt;
    logic        ex_branch_taken;
    logic [9:0]  mem_ctrl;
    logic        mem_ready;
    logic        pc_we;
    logic        ifid_we;
    logic        ifid_flush;
    logic        idex_we;
    logic        exmem_we;
    logic [9:0]  ctrl_out;
    logic        mem_req;
    logic [15:0] stall_cnt;
    logic        timeout_err;
    logic [1:0]  state;

    modport master (
        input  id_rs, id_rt, id_ctrl, ex_ctrl, ex_rt, ex_branch_taken, mem_ctrl, mem_ready,
        output pc_we, ifid_we, ifid_flush, idex_we, exmem_we, ctrl_out, mem_req,
               stall_cnt, timeout_err, state
    );

    modport slave (
        output id_rs, id_rt, id_ctrl, ex_ctrl, ex_rt, ex_branch_taken, mem_ctrl, mem_ready,
        input  pc_we, ifid_we, ifid_flush, idex_we, exmem_we, ctrl_out, mem_req,
               stall_cnt, timeout_err, state
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, branch/jump flushes and data-memory
// waits with timeout. Decoded outputs are Mealy functions of the state and inputs.
module hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned MEM_TIMEOUT  = 15
) (
    input logic           clk,
    input logic           rst_n,
    hazard_ctrl_if.master bus
);
    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMemWait = 2'd1,
        StFlush   = 2'd2,
        StHalt    = 2'd3
    } state_e;

    localparam logic [1:0] FlushInit  = 2'(FLUSH_CYCLES - 1);
    localparam logic [7:0] TimeoutVal = 8'(MEM_TIMEOUT);

    state_e      state_q, state_d;
    logic [1:0]  flush_cnt_q, flush_cnt_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [15:0] stall_cnt_q;
    logic        timeout_err_q, timeout_err_d;

    logic       mem_access, load_use, freeze;
    logic       pc_we, ifid_we, ifid_flush, idex_we, exmem_we, mem_req;
    logic [9:0] ctrl_out;

    // Only the load/store bits of the downstream control words matter here.
    logic unused_ctrl_bits;
    assign unused_ctrl_bits = ^{bus.ex_ctrl[9:5], bus.ex_ctrl[3:0], bus.mem_ctrl[9:5],
                                bus.mem_ctrl[2:0]};

    assign mem_access = bus.mem_ctrl[4] | bus.mem_ctrl[3];
    assign load_use   = bus.ex_ctrl[4] && (bus.ex_rt != 5'd0) &&
                        ((bus.ex_rt == bus.id_rs) || (bus.ex_rt == bus.id_rt));

    always_comb begin
        state_d       = state_q;
        flush_cnt_d   = flush_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        timeout_err_d = timeout_err_q;
        freeze        = 1'b0;
        pc_we         = 1'b1;
        ifid_we       = 1'b1;
        ifid_flush    = 1'b0;
        idex_we       = 1'b1;
        exmem_we      = 1'b1;
        mem_req       = 1'b0;
        ctrl_out      = bus.id_ctrl;

        unique case (state_q)
            StRun: begin
                mem_req = mem_access;
                if (mem_access && !bus.mem_ready) begin
                    freeze     = 1'b1;
                    state_d    = StMemWait;
                    wait_cnt_d = 8'd1;
                end else if (bus.ex_branch_taken) begin
                    ifid_flush = 1'b1;
                    ctrl_out   = 10'd0;
                    if (FLUSH_CYCLES > 1) begin
                        state_d     = StFlush;
                        flush_cnt_d = FlushInit;
                    end
                end else if (load_use) begin
                    pc_we    = 1'b0;
                    ifid_we  = 1'b0;
                    ctrl_out = 10'd0;
                end else if (bus.id_ctrl[9]) begin
                    ifid_flush = 1'b1;
                end
            end
            StMemWait: begin
                freeze = 1'b1;
                if (bus.mem_ready) begin
                    // Resume an interrupted branch flush if slots remain.
                    state_d = (flush_cnt_q != 2'd0) ? StFlush : StRun;
                end else if (wait_cnt_q == TimeoutVal) begin
                    state_d       = StHalt;
                    timeout_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            StFlush: begin
                mem_req = mem_access;
                if (mem_access && !bus.mem_ready) begin
                    freeze     = 1'b1;
                    state_d    = StMemWait;
                    wait_cnt_d = 8'd1;
                end else begin
                    ifid_flush  = 1'b1;
                    ctrl_out    = 10'd0;
                    flush_cnt_d = flush_cnt_q - 2'd1;
                    if (flush_cnt_q <= 2'd1) begin
                        state_d     = StRun;
                        flush_cnt_d = 2'd0;
                    end
                end
            end
            StHalt: begin
                pc_we    = 1'b0;
                ifid_we  = 1'b0;
                idex_we  = 1'b0;
                exmem_we = 1'b0;
                ctrl_out = 10'd0;
            end
            default: state_d = StRun;
        endcase

        if (freeze) begin
            pc_we    = 1'b0;
            ifid_we  = 1'b0;
            idex_we  = 1'b0;
            exmem_we = 1'b0;
            mem_req  = 1'b1;
            ctrl_out = bus.id_ctrl;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StRun;
            flush_cnt_q   <= 2'd0;
            wait_cnt_q    <= 8'd0;
            stall_cnt_q   <= 16'd0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            flush_cnt_q   <= flush_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_d;
            if (!pc_we && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    assign bus.pc_we       = pc_we;
    assign bus.ifid_we     = ifid_we;
    assign bus.ifid_flush  = ifid_flush;
    assign bus.idex_we     = idex_we;
    assign bus.exmem_we    = exmem_we;
    assign bus.ctrl_out    = ctrl_out;
    assign bus.mem_req     = mem_req;
    assign bus.stall_cnt   = stall_cnt_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.state       = state_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: table of single-cycle RUN vectors plus hand-written
// sequences for branch flush, memory wait, timeout, async reset and counter saturation.
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_ctrl_if bus();

    hazard_ctrl #(
        .FLUSH_CYCLES(2),
        .MEM_TIMEOUT (15)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [9:0] idc;
        logic [9:0] exc;
        logic [4:0] exrt;
        logic [9:0] memc;
        logic       rdy;
        logic       pc;
        logic       ifid;
        logic       fl;
        logic       idex;
        logic       exm;
        logic       mreq;
        logic [9:0] ctrl;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;
    int exp_stall = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string name, input logic pc, input logic ifid,
                              input logic fl, input logic idex, input logic exm,
                              input logic mreq, input logic [9:0] ctrl);
        check({name, ".pc_we"}, 16'(bus.pc_we), 16'(pc));
        check({name, ".ifid_we"}, 16'(bus.ifid_we), 16'(ifid));
        check({name, ".ifid_flush"}, 16'(bus.ifid_flush), 16'(fl));
        check({name, ".idex_we"}, 16'(bus.idex_we), 16'(idex));
        check({name, ".exmem_we"}, 16'(bus.exmem_we), 16'(exm));
        check({name, ".mem_req"}, 16'(bus.mem_req), 16'(mreq));
        check({name, ".ctrl_out"}, 16'(bus.ctrl_out), 16'(ctrl));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.id_rs = 5'd0;
        bus.id_rt = 5'd0;
        bus.id_ctrl = 10'h123;
        bus.ex_ctrl = 10'h000;
        bus.ex_rt = 5'd0;
        bus.ex_branch_taken = 1'b0;
        bus.mem_ctrl = 10'h000;
        bus.mem_ready = 1'b0;
    endtask

    vec_t vecs[10];

    initial begin
        vecs[0] = '{5'd0, 5'd0, 10'h123, 10'h000, 5'd0, 10'h000, 1'b0,
                    1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 10'h123};
        vecs[1] = '{5'd5, 5'd0, 10'h022, 10'h030, 5'd5, 10'h000, 1'b0,
                    1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 10'h000};
        vecs[2] = '{5'd3, 5'd5, 10'h022, 10'h030, 5'd5, 10'h000, 1'b0,
                    1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 10'h000};
        vecs[3] = '{5'd0, 5'd0, 10'h045, 10'h030, 5'd0, 10'h000, 1'b0,
                    1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 10'h045};
        vecs[4] = '{5'd5, 5'd0, 10'h045, 10'h020, 5'd5, 10'h000, 1'b0,
                    1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 10'h045};
        vecs[5] = '{5'd1, 5'd2, 10'h200, 10'h000, 5'd0, 10'h000, 1'b0,
                    1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 10'h200};
        vecs[6] = '{5'd0, 5'd0, 10'h0A1, 10'h000, 5'd0, 10'h010, 1'b1,
                    1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 10'h0A1};
        vecs[7] = '{5'd7, 5'd0, 10'h2A0, 10'h030, 5'd7, 10'h000, 1'b0,
                    1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 10'h000};
        vecs[8] = '{5'd5, 5'd0, 10'h022, 10'h030, 5'd5, 10'h008, 1'b1,
                    1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 10'h000};
        vecs[9] = '{5'd1, 5'd2, 10'h033, 10'h030, 5'd4, 10'h000, 1'b0,
                    1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 10'h033};

        // Reset state
        idle_inputs();
        #2;
        check("rst.state", 16'(bus.state), 16'd0);
        check("rst.stall_cnt", bus.stall_cnt, 16'd0);
        check("rst.timeout_err", 16'(bus.timeout_err), 16'd0);
        check_outs("rst", 1, 1, 0, 1, 1, 0, 10'h123);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Single-cycle RUN vectors
        for (int i = 0; i < 10; i++) begin
            bus.id_rs = vecs[i].rs;
            bus.id_rt = vecs[i].rt;
            bus.id_ctrl = vecs[i].idc;
            bus.ex_ctrl = vecs[i].exc;
            bus.ex_rt = vecs[i].exrt;
            bus.mem_ctrl = vecs[i].memc;
            bus.mem_ready = vecs[i].rdy;
            #1;
            check_outs($sformatf("vec%0d", i), vecs[i].pc, vecs[i].ifid, vecs[i].fl,
                       vecs[i].idex, vecs[i].exm, vecs[i].mreq, vecs[i].ctrl);
            tick();
            if (!vecs[i].pc) exp_stall++;
            check($sformatf("vec%0d.stall_cnt", i), bus.stall_cnt, 16'(exp_stall));
            check($sformatf("vec%0d.state", i), 16'(bus.state), 16'd0);
        end

        // Taken branch: two flushed slots, RUN -> FLUSH -> RUN
        idle_inputs();
        bus.ex_branch_taken = 1'b1;
        #1;
        check_outs("br0", 1, 1, 1, 1, 1, 0, 10'h000);
        tick();
        bus.ex_branch_taken = 1'b0;
        #1;
        check("br1.state", 16'(bus.state), 16'd2);
        check_outs("br1", 1, 1, 1, 1, 1, 0, 10'h000);
        tick();
        check("br2.state", 16'(bus.state), 16'd0);
        check_outs("br2", 1, 1, 0, 1, 1, 0, 10'h123);

        // Branch together with load-use: flush wins, no stall
        bus.ex_branch_taken = 1'b1;
        bus.ex_ctrl = 10'h030;
        bus.ex_rt = 5'd5;
        bus.id_rs = 5'd5;
        #1;
        check_outs("brlu0", 1, 1, 1, 1, 1, 0, 10'h000);
        tick();
        bus.ex_branch_taken = 1'b0;
        #1;
        check("brlu1.state", 16'(bus.state), 16'd2);
        check("brlu1.pc_we", 16'(bus.pc_we), 16'd1);
        tick();
        idle_inputs();
        #1;
        check("brlu2.state", 16'(bus.state), 16'd0);
        check("brlu2.stall_cnt", bus.stall_cnt, 16'(exp_stall));

        // Memory wait: ready low 3 cycles, 4 frozen cycles; branch ignored while frozen
        bus.mem_ctrl = 10'h008;
        #1;
        check_outs("mw0", 0, 0, 0, 0, 0, 1, 10'h123);
        tick();
        check("mw1.state", 16'(bus.state), 16'd1);
        check("mw1.mem_req", 16'(bus.mem_req), 16'd1);
        bus.ex_branch_taken = 1'b1;
        #1;
        check("mw1.ifid_flush", 16'(bus.ifid_flush), 16'd0);
        check("mw1.pc_we", 16'(bus.pc_we), 16'd0);
        tick();
        bus.ex_branch_taken = 1'b0;
        check("mw2.state", 16'(bus.state), 16'd1);
        tick();
        bus.mem_ready = 1'b1;
        #1;
        check_outs("mw3", 0, 0, 0, 0, 0, 1, 10'h123);
        tick();
        exp_stall += 4;
        idle_inputs();
        #1;
        check("mw4.state", 16'(bus.state), 16'd0);
        check("mw4.stall_cnt", bus.stall_cnt, 16'(exp_stall));
        check("mw4.pc_we", 16'(bus.pc_we), 16'd1);

        // Flush interrupted by a memory wait resumes in FLUSH
        bus.ex_branch_taken = 1'b1;
        tick();
        bus.ex_branch_taken = 1'b0;
        bus.mem_ctrl = 10'h010;
        #1;
        check("fi0.state", 16'(bus.state), 16'd2);
        check_outs("fi0", 0, 0, 0, 0, 0, 1, 10'h123);
        tick();
        check("fi1.state", 16'(bus.state), 16'd1);
        bus.mem_ready = 1'b1;
        tick();
        idle_inputs();
        #1;
        check("fi2.state", 16'(bus.state), 16'd2);
        check_outs("fi2", 1, 1, 1, 1, 1, 0, 10'h000);
        tick();
        exp_stall += 2;
        check("fi3.state", 16'(bus.state), 16'd0);
        check("fi3.stall_cnt", bus.stall_cnt, 16'(exp_stall));

        // Ready on the timeout cycle wins
        bus.mem_ctrl = 10'h008;
        tick();
        for (int i = 0; i < 14; i++) tick();
        bus.mem_ready = 1'b1;
        #1;
        check("rw.state", 16'(bus.state), 16'd1);
        tick();
        idle_inputs();
        exp_stall += 16;
        check("rw.state_after", 16'(bus.state), 16'd0);
        check("rw.timeout_err", 16'(bus.timeout_err), 16'd0);
        check("rw.stall_cnt", bus.stall_cnt, 16'(exp_stall));

        // Timeout: 15 wait cycles then HALT
        bus.mem_ctrl = 10'h008;
        tick();
        for (int i = 1; i <= 15; i++) begin
            check($sformatf("to.wait%0d.state", i), 16'(bus.state), 16'd1);
            tick();
        end
        exp_stall += 16;
        check("to.state", 16'(bus.state), 16'd3);
        check("to.timeout_err", 16'(bus.timeout_err), 16'd1);
        check_outs("to", 0, 0, 0, 0, 0, 0, 10'h000);
        check("to.stall_cnt", bus.stall_cnt, 16'(exp_stall));
        for (int i = 0; i < 3; i++) tick();
        exp_stall += 3;
        check("halt.stall_cnt", bus.stall_cnt, 16'(exp_stall));
        check("halt.state", 16'(bus.state), 16'd3);

        // Asynchronous reset mid-HALT, no clock edge in between
        #1 rst_n = 1'b0;
        #1;
        check("arst.state", 16'(bus.state), 16'd0);
        check("arst.timeout_err", 16'(bus.timeout_err), 16'd0);
        check("arst.stall_cnt", bus.stall_cnt, 16'd0);
        #1 rst_n = 1'b1;

        // Saturation: re-enter HALT and run past 65535 stalled cycles
        tick();
        for (int i = 0; i < 16; i++) tick();
        check("sat.state", 16'(bus.state), 16'd3);
        check("sat.stall_cnt_early", bus.stall_cnt, 16'd17);
        for (int i = 0; i < 65600; i++) tick();
        check("sat.stall_cnt", bus.stall_cnt, 16'hFFFF);
        for (int i = 0; i < 10; i++) tick();
        check("sat.stall_cnt_hold", bus.stall_cnt, 16'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
